// File: rtl/etapa_wb_pipe.sv
// MEM/WB write-back stage: load-lane extraction/extension, write-back mux, registered outputs.
// Optional retired-instruction counter enabled by defining ETAPA_WB_RETIRE_CNT_EN. DATA_W is 32 or 64.
module etapa_wb_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_valid,
    input  logic                          i_stall,
    input  logic                          i_flush,
    input  logic [REG_ADDR_W-1:0]         i_write_reg,
    input  logic [DATA_W-1:0]             i_ALU_result,
    input  logic [DATA_W-1:0]             i_read_data,
    input  logic [$clog2(DATA_W/8)-1:0]   i_addr_lsb,
    input  logic [1:0]                    i_mem_size,
    input  logic                          i_mem_unsigned,
    input  logic                          i_WB_write,
    input  logic                          i_WB_mem_to_reg,
    output logic [REG_ADDR_W-1:0]         o_write_reg,
    output logic [DATA_W-1:0]             o_WB_data,
    output logic                          o_WB_write,
    output logic                          o_valid,
    output logic [CNT_W-1:0]              o_retired_count
);

    localparam int LANE_W = $clog2(DATA_W / 8);

    logic [LANE_W-2:0]   half_idx_s;
    logic                word_idx_s;
    logic [7:0]          byte_s;
    logic [15:0]         half_s;
    logic [31:0]         word_s;
    logic                byte_sign_s;
    logic                half_sign_s;
    logic                word_sign_s;
    logic [DATA_W-1:0]   mem_data_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                wb_write_s;

    logic                valid_r;
    logic                wb_write_r;
    logic [REG_ADDR_W-1:0] write_reg_r;
    logic [DATA_W-1:0]   wb_data_r;

    // Address bits below the access size are dropped by taking only the upper lane bits.
    assign half_idx_s  = i_addr_lsb[LANE_W-1:1];
    assign word_idx_s  = i_addr_lsb[LANE_W-1];
    assign byte_s      = 8'(i_read_data >> {i_addr_lsb, 3'b000});
    assign half_s      = 16'(i_read_data >> {half_idx_s, 4'b0000});
    assign word_s      = 32'(i_read_data >> {word_idx_s, 5'b00000});
    assign byte_sign_s = ~i_mem_unsigned & byte_s[7];
    assign half_sign_s = ~i_mem_unsigned & half_s[15];
    assign word_sign_s = ~i_mem_unsigned & word_s[31];

    // Size the loaded lane and extend it to the register width.
    always_comb begin
        mem_data_s = i_read_data;
        case (i_mem_size)
            2'b00: mem_data_s = {{(DATA_W-8){byte_sign_s}}, byte_s};
            2'b01: mem_data_s = {{(DATA_W-16){half_sign_s}}, half_s};
            2'b10: begin
                if (DATA_W == 64) begin
                    mem_data_s = DATA_W'({{32{word_sign_s}}, word_s});
                end else begin
                    mem_data_s = i_read_data;
                end
            end
            default: mem_data_s = i_read_data;
        endcase
    end

    assign sel_data_s = i_WB_mem_to_reg ? i_ALU_result : mem_data_s;
    assign wb_write_s = i_valid & i_WB_write & (i_write_reg != {REG_ADDR_W{1'b0}});

    // Stage register: reset beats flush beats stall beats load.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            valid_r     <= 1'b0;
            wb_write_r  <= 1'b0;
            write_reg_r <= {REG_ADDR_W{1'b0}};
            wb_data_r   <= {DATA_W{1'b0}};
        end else if (i_flush) begin
            valid_r    <= 1'b0;
            wb_write_r <= 1'b0;
        end else if (i_stall) begin
            valid_r    <= valid_r;
            wb_write_r <= wb_write_r;
        end else begin
            valid_r     <= i_valid;
            wb_write_r  <= wb_write_s;
            write_reg_r <= i_write_reg;
            wb_data_r   <= sel_data_s;
        end
    end

    assign o_valid     = valid_r;
    assign o_WB_write  = wb_write_r;
    assign o_write_reg = write_reg_r;
    assign o_WB_data   = wb_data_r;

`ifdef ETAPA_WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_cnt_r;

    // Count live instructions accepted on a load edge; wraps silently.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            retired_cnt_r <= {CNT_W{1'b0}};
        end else if (!i_flush && !i_stall && i_valid) begin
            retired_cnt_r <= retired_cnt_r + CNT_W'(1);
        end else begin
            retired_cnt_r <= retired_cnt_r;
        end
    end

    assign o_retired_count = retired_cnt_r;
`else
    assign o_retired_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_etapa_wb_pipe.sv
// Directed bench for etapa_wb_pipe: a 32-bit instance (4-bit counter) and a 64-bit instance.
module tb_etapa_wb_pipe;

`ifdef ETAPA_WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, valid, stall, flush, wbw, m2r, uns;
    logic [4:0]  wreg;
    logic [1:0]  size;
    logic [31:0] alu32, rd32;
    logic [63:0] alu64, rd64;
    logic [1:0]  lsb32;
    logic [2:0]  lsb64;

    logic [4:0]  o_reg32, o_reg64;
    logic [31:0] o_data32;
    logic [63:0] o_data64;
    logic        o_wbw32, o_wbw64, o_valid32, o_valid64;
    logic [3:0]  o_cnt32;
    logic [31:0] o_cnt64;

    int n_checks = 0;
    int n_fail   = 0;
    int loads    = 0;

    always #5 clk = ~clk;

    etapa_wb_pipe #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) dut32 (
        .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_write_reg(wreg), .i_ALU_result(alu32), .i_read_data(rd32), .i_addr_lsb(lsb32),
        .i_mem_size(size), .i_mem_unsigned(uns), .i_WB_write(wbw), .i_WB_mem_to_reg(m2r),
        .o_write_reg(o_reg32), .o_WB_data(o_data32), .o_WB_write(o_wbw32),
        .o_valid(o_valid32), .o_retired_count(o_cnt32)
    );

    etapa_wb_pipe #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(32)) dut64 (
        .i_clk(clk), .i_reset(reset), .i_valid(valid), .i_stall(stall), .i_flush(flush),
        .i_write_reg(wreg), .i_ALU_result(alu64), .i_read_data(rd64), .i_addr_lsb(lsb64),
        .i_mem_size(size), .i_mem_unsigned(uns), .i_WB_write(wbw), .i_WB_mem_to_reg(m2r),
        .o_write_reg(o_reg64), .o_WB_data(o_data64), .o_WB_write(o_wbw64),
        .o_valid(o_valid64), .o_retired_count(o_cnt64)
    );

    typedef struct {
        bit          wide;
        logic        m2r;
        logic [1:0]  size;
        logic [2:0]  lsb;
        logic        uns;
        logic [63:0] rd;
        logic [63:0] alu;
        logic        valid;
        logic        wbw;
        logic [4:0]  wreg;
        logic [63:0] exp_data;
        logic        exp_wbw;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_cnt(input int n);
        if (CNT_EN) return 4'(n);
        else return 4'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [4:0] r, input logic [63:0] a, input logic v);
        m2r = 1'b1; wbw = 1'b1; wreg = r; valid = v;
        alu32 = a[31:0]; alu64 = a;
    endtask

    task automatic check_regs(input string name, input logic [4:0] r, input logic [31:0] d,
                              input logic v, input logic w);
        check({name, "_reg"},   64'(o_reg32),   64'(r));
        check({name, "_data"},  64'(o_data32),  64'(d));
        check({name, "_valid"}, 64'(o_valid32), 64'(v));
        check({name, "_wbw"},   64'(o_wbw32),   64'(w));
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 2'b00, 3'd1, 1'b0, 64'h80FF7F01, 64'h0, 1'b1, 1'b1, 5'd1, 64'h0000007F, 1'b1};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 3'd3, 1'b0, 64'h80FF7F01, 64'h0, 1'b1, 1'b1, 5'd2, 64'hFFFFFF80, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 3'd2, 1'b1, 64'h80FF7F01, 64'h0, 1'b1, 1'b1, 5'd3, 64'h000000FF, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 2'b00, 3'd0, 1'b0, 64'h80FF7F01, 64'h0, 1'b1, 1'b1, 5'd4, 64'h00000001, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 2'b01, 3'd2, 1'b0, 64'h80011234, 64'h0, 1'b1, 1'b1, 5'd5, 64'hFFFF8001, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 2'b01, 3'd2, 1'b1, 64'h80011234, 64'h0, 1'b1, 1'b1, 5'd6, 64'h00008001, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 2'b01, 3'd3, 1'b0, 64'h80011234, 64'h0, 1'b1, 1'b1, 5'd7, 64'hFFFF8001, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 2'b01, 3'd0, 1'b0, 64'h80011234, 64'h0, 1'b1, 1'b1, 5'd8, 64'h00001234, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 2'b10, 3'd3, 1'b0, 64'h80011234, 64'h0, 1'b1, 1'b1, 5'd9, 64'h80011234, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 2'b11, 3'd1, 1'b0, 64'h80011234, 64'h0, 1'b1, 1'b1, 5'd10, 64'h80011234, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 2'b00, 3'd0, 1'b0, 64'h0, 64'h55, 1'b1, 1'b1, 5'd0, 64'h00000055, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 2'b00, 3'd0, 1'b0, 64'h0, 64'hDEADBEEF, 1'b1, 1'b1, 5'd5, 64'hDEADBEEF, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 2'b00, 3'd0, 1'b0, 64'h0, 64'h12345678, 1'b0, 1'b1, 5'd5, 64'h12345678, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 2'b00, 3'd0, 1'b0, 64'h0, 64'h0000CAFE, 1'b1, 1'b0, 5'd3, 64'h0000CAFE, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 2'b10, 3'd4, 1'b0, 64'h8000000000000001, 64'h0, 1'b1, 1'b1, 5'd11, 64'hFFFFFFFF80000000, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 2'b10, 3'd4, 1'b1, 64'h8000000000000001, 64'h0, 1'b1, 1'b1, 5'd12, 64'h0000000080000000, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 2'b10, 3'd3, 1'b0, 64'h8000000000000001, 64'h0, 1'b1, 1'b1, 5'd13, 64'h0000000000000001, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 2'b11, 3'd5, 1'b0, 64'h8000000000000001, 64'h0, 1'b1, 1'b1, 5'd14, 64'h8000000000000001, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 2'b00, 3'd7, 1'b0, 64'h8000000000000001, 64'h0, 1'b1, 1'b1, 5'd15, 64'hFFFFFFFFFFFFFF80, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 2'b01, 3'd6, 1'b1, 64'h8000000000000001, 64'h0, 1'b1, 1'b1, 5'd16, 64'h0000000000008000, 1'b1};

        reset = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0; wbw = 1'b0; m2r = 1'b0; uns = 1'b0;
        wreg = 5'd0; size = 2'b00; alu32 = 32'h0; alu64 = 64'h0; rd32 = 32'h0; rd64 = 64'h0;
        lsb32 = 2'd0; lsb64 = 3'd0;
        tick(); tick();
        check_regs("por", 5'd0, 32'h0, 1'b0, 1'b0);
        check("por_cnt", 64'(o_cnt32), 64'(exp_cnt(0)));

        // Reset wins over stall and flush and clears a loaded instruction.
        reset = 1'b0;
        set_alu(5'd7, 64'h11, 1'b1);
        tick(); loads++;
        check_regs("pre_rst", 5'd7, 32'h11, 1'b1, 1'b1);
        reset = 1'b1; stall = 1'b1; flush = 1'b1;
        tick(); loads = 0;
        check_regs("rst_prio", 5'd0, 32'h0, 1'b0, 1'b0);
        check("rst_prio_cnt", 64'(o_cnt32), 64'(exp_cnt(0)));
        reset = 1'b0; stall = 1'b0; flush = 1'b0;

        for (int i = 0; i < 20; i++) begin
            m2r = vecs[i].m2r; size = vecs[i].size; uns = vecs[i].uns;
            lsb32 = vecs[i].lsb[1:0]; lsb64 = vecs[i].lsb;
            rd32 = vecs[i].rd[31:0]; rd64 = vecs[i].rd;
            alu32 = vecs[i].alu[31:0]; alu64 = vecs[i].alu;
            valid = vecs[i].valid; wbw = vecs[i].wbw; wreg = vecs[i].wreg;
            tick();
            if (vecs[i].valid) loads++;
            if (vecs[i].wide) begin
                check($sformatf("v%0d_data64", i), o_data64, vecs[i].exp_data);
                check($sformatf("v%0d_wbw64", i), 64'(o_wbw64), 64'(vecs[i].exp_wbw));
            end else begin
                check($sformatf("v%0d_data32", i), 64'(o_data32), vecs[i].exp_data);
                check($sformatf("v%0d_wbw32", i), 64'(o_wbw32), 64'(vecs[i].exp_wbw));
            end
            check($sformatf("v%0d_valid", i), 64'(o_valid32), 64'(vecs[i].valid));
            check($sformatf("v%0d_reg", i), 64'(o_reg32), 64'(vecs[i].wreg));
        end
        check("vec_cnt", 64'(o_cnt32), 64'(exp_cnt(loads)));

        // Stall holds everything for three cycles; stall+flush then kills valid only.
        set_alu(5'd7, 64'h11, 1'b1);
        tick(); loads++;
        check_regs("stl_load", 5'd7, 32'h11, 1'b1, 1'b1);
        set_alu(5'd9, 64'h22, 1'b1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_regs($sformatf("stl_hold%0d", k), 5'd7, 32'h11, 1'b1, 1'b1);
            check($sformatf("stl_cnt%0d", k), 64'(o_cnt32), 64'(exp_cnt(loads)));
        end
        flush = 1'b1;
        tick();
        check_regs("stl_flush", 5'd7, 32'h11, 1'b0, 1'b0);
        check("stl_flush_cnt", 64'(o_cnt32), 64'(exp_cnt(loads)));
        stall = 1'b0; flush = 1'b0;

        // Counter wrap: from reset, 17 valid loads on a 4-bit counter leave 1.
        reset = 1'b1;
        tick(); loads = 0;
        reset = 1'b0;
        for (int k = 0; k < 17; k++) begin
            set_alu(5'(k + 1), 64'(k), 1'b1);
            tick(); loads++;
        end
        check("cnt_wrap", 64'(o_cnt32), 64'(exp_cnt(1)));
        flush = 1'b1;
        set_alu(5'd20, 64'h99, 1'b1);
        tick();
        flush = 1'b0;
        check("cnt_flush", 64'(o_cnt32), 64'(exp_cnt(1)));
        check("cnt_flush_valid", 64'(o_valid32), 64'h0);
        check("cnt_flush_data", 64'(o_data32), 64'h10);
        reset = 1'b1;
        tick(); loads = 0;
        reset = 1'b0;
        check("cnt_reset", 64'(o_cnt32), 64'(exp_cnt(0)));
        check("cnt64_zero", 64'(o_cnt64), 64'h0);

        // Reset during a stall drops the held instruction; next load is normal.
        set_alu(5'd3, 64'h33, 1'b1);
        tick(); loads++;
        stall = 1'b1; reset = 1'b1;
        set_alu(5'd6, 64'h66, 1'b1);
        tick(); loads = 0;
        check_regs("rst_stall", 5'd0, 32'h0, 1'b0, 1'b0);
        stall = 1'b0; reset = 1'b0;
        set_alu(5'd4, 64'h44, 1'b1);
        tick(); loads++;
        check_regs("post_rst", 5'd4, 32'h44, 1'b1, 1'b1);
        check("post_rst_cnt", 64'(o_cnt32), 64'(exp_cnt(loads)));
        check("post_rst_data64", o_data64, 64'h44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
